// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART-driven ALU command sequencer:
// FSM state codes, ALU opcodes and the operand byte-count helper.
package alu_uart_pkg;

  localparam logic [2:0] RX_A    = 3'd0;
  localparam logic [2:0] RX_B    = 3'd1;
  localparam logic [2:0] RX_OP   = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] TX_SEND = 3'd4;
  localparam logic [2:0] TX_WAIT = 3'd5;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SRA = 6'b000011;
  localparam logic [5:0] ALU_SRL = 6'b000010;
  localparam logic [5:0] ALU_NOR = 6'b100111;

  function automatic int nbytes(input int bus_reg);
    return bus_reg / 8;
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_tx_ser.sv
// Result register and byte serializer: latches the ALU result on load,
// then emits one byte per send strobe, advancing on each tx ack.
module alu_uart_tx_ser
  import alu_uart_pkg::*;
#(
  parameter int BUS_REG = 16,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [BUS_REG-1:0] i_result,
  input  logic               i_send,
  input  logic               i_ack,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_last
);

  localparam int NBYTES = nbytes(BUS_REG);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [BUS_REG-1:0] res_q, res_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_BYTE-1:0] data_q, data_d;
  logic               start_q, start_d;

  assign o_last     = (cnt_q == CW'(NBYTES - 1));
  assign o_tx_data  = data_q;
  assign o_tx_start = start_q;

  always_comb begin
    res_d   = res_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    start_d = 1'b0;
    if (i_load) begin
      res_d = i_result;
      cnt_d = '0;
    end
    if (i_send) begin
      data_d  = res_q[NB_BYTE*cnt_q +: NB_BYTE];
      start_d = 1'b1;
    end
    if (i_ack && !o_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// UART command sequencer: assembles A/B/opcode frames, runs the ALU, returns
// the result bytewise. INTERBYTE_TIMEOUT_EN adds an abandoned-frame timeout.
module alu_uart_sequencer
  import alu_uart_pkg::*;
#(
  parameter int BUS_REG     = 16,
  parameter int BUS_OP      = 6,
  parameter int NB_BYTE     = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [BUS_REG-1:0] i_result,
  output logic [BUS_REG-1:0] o_valA,
  output logic [BUS_REG-1:0] o_valB,
  output logic [BUS_OP-1:0]  o_opcode,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_rx_drop
);

  localparam int NBYTES = nbytes(BUS_REG);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BUS_REG-1:0] vala_q, vala_d;
  logic [BUS_REG-1:0] valb_q, valb_d;
  logic [BUS_OP-1:0]  op_q, op_d;
  logic               drop_q, drop_d;
  logic               cnt_last;
  logic               ser_last;
  logic               tmo_hit;

  assign cnt_last  = (cnt_q == CW'(NBYTES - 1));
  assign o_busy    = (state_q == EXEC) || (state_q == TX_SEND) ||
                     (state_q == TX_WAIT);
  assign o_valA    = vala_q;
  assign o_valB    = valb_q;
  assign o_opcode  = op_q;
  assign o_rx_drop = drop_q;

`ifdef INTERBYTE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_run;

  // Only a partially received frame can time out.
  assign tmo_run = (state_q == RX_B) || (state_q == RX_OP) ||
                   ((state_q == RX_A) && (cnt_q != '0));
  assign tmo_hit = tmo_run && !i_rx_done &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (tmo_run && !i_rx_done && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    op_d    = op_q;
    drop_d  = i_rx_done && o_busy;
    unique case (state_q)
      RX_A: begin
        if (i_rx_done) begin
          vala_d[NB_BYTE*cnt_q +: NB_BYTE] = i_rx_data;
          cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
          if (cnt_last) state_d = RX_B;
        end
      end
      RX_B: begin
        if (i_rx_done) begin
          valb_d[NB_BYTE*cnt_q +: NB_BYTE] = i_rx_data;
          cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
          if (cnt_last) state_d = RX_OP;
        end
      end
      RX_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[BUS_OP-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d   = '0;
        state_d = TX_SEND;
      end
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) state_d = ser_last ? RX_A : TX_SEND;
      end
      default: begin
        state_d = RX_A;
        cnt_d   = '0;
      end
    endcase
    if (tmo_hit) begin
      state_d = RX_A;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RX_A;
      cnt_q   <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      op_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      op_q    <= op_d;
      drop_q  <= drop_d;
    end
  end

  alu_uart_tx_ser #(
    .BUS_REG (BUS_REG),
    .NB_BYTE (NB_BYTE)
  ) u_tx_ser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (state_q == EXEC),
    .i_result   (i_result),
    .i_send     (state_q == TX_SEND),
    .i_ack      ((state_q == TX_WAIT) && i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_last     (ser_last)
  );

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: random frames against a
// byte-queue frame model and an arithmetic ALU model.
module tb_alu_uart_sequencer;
  import alu_uart_pkg::*;

  localparam int W   = 16;
  localparam int OPW = 6;
  localparam int NB  = W / 8;
  localparam int TMO = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     rx_data;
  logic           rx_done;
  logic           tx_done;
  logic [W-1:0]   result;
  logic [W-1:0]   valA, valB;
  logic [OPW-1:0] opcode;
  logic [7:0]     tx_data;
  logic           tx_start, busy, rx_drop;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .BUS_REG (W),
    .BUS_OP (OPW),
    .NB_BYTE (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk (clk),
    .i_rst_n (rst_n),
    .i_rx_data (rx_data),
    .i_rx_done (rx_done),
    .i_tx_done (tx_done),
    .i_result (result),
    .o_valA (valA),
    .o_valB (valB),
    .o_opcode (opcode),
    .o_tx_data (tx_data),
    .o_tx_start (tx_start),
    .o_busy (busy),
    .o_rx_drop (rx_drop)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [OPW-1:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SRA: return W'($signed(a) >>> b);
      ALU_SRL: return a >> b;
      ALU_NOR: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign result = alu_f(valA, valB, opcode);

  int compared = 0;
  int mismatched = 0;
  int exp_drops = 0;
  int seen_drops = 0;
  logic [7:0]     expq[$];
  logic [7:0]     mbuf[$];
  logic [W-1:0]   expA = '0, expB = '0;
  logic [OPW-1:0] expOp = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transmitted byte must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_start) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got %02h expected none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(expq.pop_front()));
        end
      end
      if (rx_drop) seen_drops++;
    end
  end

  // Transmitter model: acknowledge each start after a random delay.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_start) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic model_byte(input logic [7:0] b, output bit done);
    logic [W-1:0] r;
    logic [7:0]   ob;
    done = 1'b0;
    mbuf.push_back(b);
    if (mbuf.size() == 2 * NB + 1) begin
      for (int i = 0; i < NB; i++) begin
        expA[8*i +: 8] = mbuf[i];
        expB[8*i +: 8] = mbuf[NB+i];
      end
      ob = mbuf[2*NB];
      expOp = ob[OPW-1:0];
      r = alu_f(expA, expB, expOp);
      for (int i = 0; i < NB; i++) expq.push_back(r[8*i +: 8]);
      mbuf.delete();
      done = 1'b1;
    end
  endtask

  task automatic wait_idle(input bit drops);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      if (drops && busy && $urandom_range(0, 3) == 0) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
        exp_drops++;
      end else begin
        rx_done = 1'b0;
      end
      n++;
    end
    rx_done = 1'b0;
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  // mode 0: normal, 1: inject drops in EXEC/TX, 2: return without waiting
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit done;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, done);
    @(negedge clk);
    if (done && mode == 1) begin
      rx_data = ~b;
      rx_done = 1'b1;
      exp_drops++;
      @(negedge clk);
    end
    rx_done = 1'b0;
    if (done && mode != 2) begin
      wait_idle(mode == 1);
      check("valA", 32'(valA), 32'(expA));
      check("valB", 32'(valB), 32'(expB));
      check("opcode", 32'(opcode), 32'(expOp));
    end else if (!done) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [7:0] op, input int mode);
    for (int i = 0; i < NB; i++) send_byte(a[8*i +: 8], 0);
    for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8], 0);
    send_byte(op, mode);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_valA", 32'(valA), 0);
    check("rst_valB", 32'(valB), 0);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_drop", 32'(rx_drop), 0);
    rst_n = 1'b1;
    expq.delete();
    mbuf.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
`ifdef INTERBYTE_TIMEOUT_EN
    if (n > TMO + 2) mbuf.delete();
`endif
  endtask

  logic [5:0] ops [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] opb;
    ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
            ALU_XOR, ALU_SRA, ALU_SRL, ALU_NOR};
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    do_reset();

    send_frame(16'h0005, 16'h0003, 8'h20, 0);
    send_frame(16'h0003, 16'h0005, 8'h22, 0);
    send_frame(16'h8000, 16'h0004, 8'h03, 0);
    send_frame(16'h8000, 16'h0004, 8'h02, 0);
    send_frame(16'h0001, 16'h0002, 8'h3F, 0);
    send_frame(16'h0001, 16'h0002, 8'hE7, 0);

    send_frame(16'h1234, 16'h00F0, 8'h24, 1);
    send_frame(16'h00FF, 16'h0F0F, 8'h26, 0);
    repeat (3) @(negedge clk);
    check("drop_count", 32'(seen_drops), 32'(exp_drops));

    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    do_reset();
    repeat (5) @(negedge clk);
    send_frame(16'h0707, 16'h0101, 8'h20, 2);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (15) @(negedge clk);
    send_frame(16'h000A, 16'h000A, 8'h24, 0);

    send_byte(8'h05, 0);
    idle(60);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    while (mbuf.size() != 0) send_byte(8'($urandom), 0);

    for (int f = 0; f < 30; f++) begin
      opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      if ($urandom_range(0, 5) == 0) opb = 8'($urandom);
      send_frame(W'($urandom), W'($urandom), opb,
                 ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    repeat (5) @(negedge clk);
    check("drop_count_final", 32'(seen_drops), 32'(exp_drops));
    check("queue_empty", 32'(expq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
